divider_sequencer: RTL and testbench

Controller for the `part3_2` cascaded 8-bit up/down counter used as a programmable frequency divider. It accepts a load value and count direction over a valid/ready handshake, then sequences the counter's `ld`/`en` controls: initial load, run, hold and auto-reload on terminal count. It emits one `div_tick` per divided period and counts completed periods. It runs on the same clock that drives the counter (the `Oscillator` output).

---
 rtl/divider_sequencer.sv | 128 ++++++++++++
 tb/tb_divider_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_sequencer.sv
// Sequencer for the part3_2 cascaded 8-bit up/down counter used as a programmable
// frequency divider: load, run, hold and auto-reload on terminal count.
module divider_sequencer #(
    parameter logic [7:0] DEFAULT_LOAD = 8'h8E,
    parameter logic       DEFAULT_DOWN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_load,
    input  logic        cfg_down,
    input  logic        start,
    input  logic        stop,
    input  logic        hold,
    input  logic        max_min,
    output logic        ld,
    output logic        en,
    output logic        DownUp,
    output logic [3:0]  load_msb,
    output logic [3:0]  load_lsb,
    output logic        div_tick,
    output logic [15:0] period_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_RELOAD
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cfg_load;
    logic        r_cfg_down;
    logic        r_ld;
    logic        r_en;
    logic        r_div_tick;
    logic        r_busy;
    logic        r_cfg_ready;
    logic [15:0] r_period_cnt;
    logic        w_cfg_accept;
    logic        w_period_inc;

    assign w_cfg_accept = cfg_valid & r_cfg_ready;
    assign w_period_inc = (r_state == S_RUN) && (w_next_state == S_RELOAD)
                          && (r_period_cnt != 16'hFFFF);

    // Stop outranks terminal count, which outranks hold.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_state = stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (stop)         w_next_state = S_IDLE;
                else if (max_min) w_next_state = S_RELOAD;
                else if (hold)    w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (stop)       w_next_state = S_IDLE;
                else if (!hold) w_next_state = S_RUN;
            end
            S_RELOAD: begin
                w_next_state = stop ? S_IDLE : S_RUN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered and
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: async reset puts every output at its idle value immediately, independent of clk.
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ld         <= 1'b1;
            r_en         <= 1'b1;
            r_div_tick   <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_ready  <= 1'b1;
            r_period_cnt <= 16'h0000;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state     <= w_next_state;
            r_ld        <= !((w_next_state == S_LOAD) || (w_next_state == S_RELOAD));
            r_en        <= (w_next_state != S_RUN);
            r_div_tick  <= (w_next_state == S_RELOAD);
            r_busy      <= (w_next_state != S_IDLE);
            r_cfg_ready <= (w_next_state == S_IDLE);
            if (w_next_state == S_LOAD) begin
                r_period_cnt <= 16'h0000;
            end else if (w_period_inc) begin
                r_period_cnt <= r_period_cnt + 16'h0001;
            end
        end
    end

    // Config accepted only in IDLE; a start in the same cycle sees the new value in LOAD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_load <= DEFAULT_LOAD;
            r_cfg_down <= DEFAULT_DOWN;
        end else if (w_cfg_accept) begin
            r_cfg_load <= cfg_load;
            r_cfg_down <= cfg_down;
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign ld         = r_ld;
    assign en         = r_en;
    assign div_tick   = r_div_tick;
    assign busy       = r_busy;
    assign period_cnt = r_period_cnt;
    assign DownUp     = r_cfg_down;
    assign load_msb   = r_cfg_load[7:4];
    assign load_lsb   = r_cfg_load[3:0];

endmodule

// File: tb/tb_divider_sequencer.sv
// Directed bench for divider_sequencer with a behavioural part3_2 counter attached;
// expected tick periods and period counts are queued at stimulus time and popped on each tick.
module tb_divider_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_load;
    logic        cfg_down;
    logic        start;
    logic        stop;
    logic        hold;
    logic        max_min;
    logic        ld;
    logic        en;
    logic        DownUp;
    logic [3:0]  load_msb;
    logic [3:0]  load_lsb;
    logic        div_tick;
    logic [15:0] period_cnt;
    logic        busy;

    logic [7:0]  cnt = 8'h00;
    int          checks = 0;
    int          errors = 0;
    int          q_period[$];
    int          q_pcnt[$];

    divider_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_load   (cfg_load),
        .cfg_down   (cfg_down),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .max_min    (max_min),
        .ld         (ld),
        .en         (en),
        .DownUp     (DownUp),
        .load_msb   (load_msb),
        .load_lsb   (load_lsb),
        .div_tick   (div_tick),
        .period_cnt (period_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // part3_2 model: synchronous active-low load, active-low enable, combinational terminal flag.
    always @(posedge clk) begin
        if (!ld)      cnt <= {load_msb, load_lsb};
        else if (!en) cnt <= DownUp ? cnt - 8'd1 : cnt + 8'd1;
    end
    assign max_min = DownUp ? (cnt == 8'h00) : (cnt == 8'hFF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_tick && n < 1000);
    endtask

    task automatic expect_tick(input string tag);
        int n;
        int exp_p;
        int exp_c;
        wait_tick(n);
        exp_p = (q_period.size() > 0) ? q_period.pop_front() : -1;
        exp_c = (q_pcnt.size() > 0) ? q_pcnt.pop_front() : -1;
        check({tag, "_period"}, n, exp_p);
        check({tag, "_pcnt"}, {16'h0, period_cnt}, exp_c);
    endtask

    task automatic cfg_start(input logic [7:0] l, input logic d);
        cfg_valid = 1'b1;
        cfg_load  = l;
        cfg_down  = d;
        start     = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int  n;
        bit  en_ok;
        bit  tick_seen;
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_load  = 8'h00;
        cfg_down  = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        hold      = 1'b0;

        // Reset state, while asserted and after 5 idle cycles.
        #12;
        check("rst_ld", ld, 1'b1);
        check("rst_en", en, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_ld", ld, 1'b1);
        check("idle_en", en, 1'b1);
        check("idle_load", {load_msb, load_lsb}, 8'h8E);
        check("idle_dir", DownUp, 1'b0);
        check("idle_ready", cfg_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_tick", div_tick, 1'b0);
        check("idle_pcnt", period_cnt, 16'h0);

        // Default config: 115-cycle period.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_ld", ld, 1'b0);
        check("load_en", en, 1'b1);
        check("load_busy", busy, 1'b1);
        check("load_ready", cfg_ready, 1'b0);
        @(negedge clk);
        check("run_ld", ld, 1'b1);
        check("run_en", en, 1'b0);
        check("run_cnt", cnt, 8'h8E);
        q_period.push_back(114); q_pcnt.push_back(1);
        q_period.push_back(115); q_pcnt.push_back(2);
        q_period.push_back(115); q_pcnt.push_back(3);
        repeat (3) expect_tick("dflt");
        @(negedge clk);
        check("tick_single", div_tick, 1'b0);
        pulse_stop();
        check("stop_busy", busy, 1'b0);
        check("stop_pcnt_kept", period_cnt, 16'd3);

        // Config 05 down with start in the same cycle: 7-cycle period.
        cfg_start(8'h05, 1'b1);
        check("cfg5_ld", ld, 1'b0);
        check("cfg5_load", {load_msb, load_lsb}, 8'h05);
        check("cfg5_dir", DownUp, 1'b1);
        check("cfg5_pcnt_clr", period_cnt, 16'h0);
        for (int i = 1; i <= 3; i++) begin
            q_period.push_back(7);
            q_pcnt.push_back(i);
        end
        repeat (3) expect_tick("down5");
        pulse_stop();

        // Hold for 10 cycles mid-run with L=8E up: stretched period of 125.
        cfg_start(8'h8E, 1'b0);
        q_period.push_back(115); q_pcnt.push_back(1);
        expect_tick("pre_hold");
        repeat (20) @(negedge clk);
        hold      = 1'b1;
        en_ok     = 1'b1;
        tick_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (en !== 1'b1) en_ok = 1'b0;
            if (div_tick !== 1'b0) tick_seen = 1'b1;
        end
        hold = 1'b0;
        check("hold_en_high", en_ok, 1'b1);
        check("hold_no_tick", tick_seen, 1'b0);
        q_period.push_back(125); q_pcnt.push_back(2);
        wait_tick(n);
        check("hold_period", 30 + n, (q_period.size() > 0) ? q_period.pop_front() : -1);
        check("hold_pcnt", period_cnt, (q_pcnt.size() > 0) ? q_pcnt.pop_front() : -1);

        // Config offered during run is refused; stop coincides with terminal count.
        cfg_valid = 1'b1;
        cfg_load  = 8'h33;
        cfg_down  = 1'b1;
        check("run_ready", cfg_ready, 1'b0);
        repeat (114) @(negedge clk);
        check("mm_at_stop", max_min, 1'b1);
        stop      = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        check("mmstop_busy", busy, 1'b0);
        check("mmstop_tick", div_tick, 1'b0);
        check("mmstop_pcnt", period_cnt, 16'd2);
        check("run_cfg_ignored", {load_msb, load_lsb, 3'b000, DownUp}, {8'h8E, 4'h0});

        // Async reset between edges mid-run.
        cfg_start(8'h40, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ld", ld, 1'b1);
        check("arst_en", en, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", cfg_ready, 1'b1);
        check("arst_pcnt", period_cnt, 16'h0);
        check("arst_load", {load_msb, load_lsb}, 8'h8E);
        check("arst_dir", DownUp, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Minimum period: L=FF up ticks every 2 cycles.
        cfg_start(8'hFF, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            q_period.push_back(2);
            q_pcnt.push_back(i);
        end
        repeat (3) expect_tick("minp");
        pulse_stop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
